// File: rtl/comparator_serial_nbit.sv
// Digit-serial magnitude comparator: walks two N-bit operands W bits per cycle, MSD first,
// in unsigned or two's-complement mode, with optional exit on the first differing digit.
//
// state | meaning
// IDLE  | waiting for start; result flags and digits_used hold the last result
// RUN   | examining one digit per cycle from the top of a_sh/b_sh
module comparator_serial_nbit #(
    parameter int N = 8,
    parameter int W = 2,
    localparam int DIGITS = N / W,
    localparam int CW = $clog2(DIGITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  A,
    input  logic [N-1:0]  B,
    input  logic          signed_mode,
    input  logic          early_exit_en,
    output logic          busy,
    output logic          done,
    output logic          Lesser,
    output logic          Greater,
    output logic          Equal,
    output logic [CW-1:0] digits_used
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [N-1:0]  a_sh_q, a_sh_d, b_sh_q, b_sh_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          decided_q, decided_d;
    logic          pend_gt_q, pend_gt_d;
    logic          ee_q, ee_d;
    logic          done_q, done_d;
    logic          lesser_q, lesser_d;
    logic          greater_q, greater_d;
    logic          equal_q, equal_d;
    logic [CW-1:0] digits_used_q, digits_used_d;

    logic [W-1:0]  digit_a, digit_b;
    logic          diff, gt, last;
    logic [N-1:0]  sign_flip;

    assign digit_a   = a_sh_q[N-1 -: W];
    assign digit_b   = b_sh_q[N-1 -: W];
    assign diff      = (digit_a != digit_b);
    assign gt        = (digit_a > digit_b);
    assign last      = (cnt_q == CW'(DIGITS - 1));
    // Offset-binary mapping: flipping the sign bit turns a signed compare into an unsigned one.
    assign sign_flip = N'(signed_mode) << (N - 1);

    always_comb begin
        state_d       = state_q;
        a_sh_d        = a_sh_q;
        b_sh_d        = b_sh_q;
        cnt_d         = cnt_q;
        decided_d     = decided_q;
        pend_gt_d     = pend_gt_q;
        ee_d          = ee_q;
        done_d        = 1'b0;
        lesser_d      = lesser_q;
        greater_d     = greater_q;
        equal_d       = equal_q;
        digits_used_d = digits_used_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d        = A ^ sign_flip;
                    b_sh_d        = B ^ sign_flip;
                    cnt_d         = '0;
                    decided_d     = 1'b0;
                    pend_gt_d     = 1'b0;
                    ee_d          = early_exit_en;
                    lesser_d      = 1'b0;
                    greater_d     = 1'b0;
                    equal_d       = 1'b0;
                    digits_used_d = '0;
                    state_d       = RUN;
                end
            end
            default: begin
                if (!decided_q && diff) begin
                    decided_d = 1'b1;
                    pend_gt_d = gt;
                end
                a_sh_d = a_sh_q << W;
                b_sh_d = b_sh_q << W;
                cnt_d  = cnt_q + CW'(1);
                if ((ee_q && diff) || last) begin
                    state_d       = IDLE;
                    done_d        = 1'b1;
                    digits_used_d = cnt_q + CW'(1);
                    // First differing digit wins; later digits never overwrite it.
                    if (decided_q) begin
                        greater_d = pend_gt_q;
                        lesser_d  = !pend_gt_q;
                    end else if (diff) begin
                        greater_d = gt;
                        lesser_d  = !gt;
                    end else begin
                        equal_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            a_sh_q        <= '0;
            b_sh_q        <= '0;
            cnt_q         <= '0;
            decided_q     <= 1'b0;
            pend_gt_q     <= 1'b0;
            ee_q          <= 1'b0;
            done_q        <= 1'b0;
            lesser_q      <= 1'b0;
            greater_q     <= 1'b0;
            equal_q       <= 1'b0;
            digits_used_q <= '0;
        end else begin
            state_q       <= state_d;
            a_sh_q        <= a_sh_d;
            b_sh_q        <= b_sh_d;
            cnt_q         <= cnt_d;
            decided_q     <= decided_d;
            pend_gt_q     <= pend_gt_d;
            ee_q          <= ee_d;
            done_q        <= done_d;
            lesser_q      <= lesser_d;
            greater_q     <= greater_d;
            equal_q       <= equal_d;
            digits_used_q <= digits_used_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = done_q;
    assign Lesser      = lesser_q;
    assign Greater     = greater_q;
    assign Equal       = equal_q;
    assign digits_used = digits_used_q;

endmodule

// File: tb/tb_comparator_serial_nbit.sv
// Directed bench for comparator_serial_nbit (N=8, W=2): latency, flags, early exit,
// start-during-run, back-to-back start and mid-run reset.
module tb_comparator_serial_nbit;

    localparam int N = 8;
    localparam int W = 2;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] A, B;
    logic       signed_mode, early_exit_en;
    logic       busy, done, Lesser, Greater, Equal;
    logic [2:0] digits_used;

    int tests_run = 0;
    int tests_failed = 0;
    int lat;
    int busy_cycles;

    comparator_serial_nbit #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .signed_mode(signed_mode), .early_exit_en(early_exit_en),
        .busy(busy), .done(done), .Lesser(Lesser), .Greater(Greater),
        .Equal(Equal), .digits_used(digits_used)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive start for the cycle t; returns in cycle t+1.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic sm, input logic ee);
        A = a;
        B = b;
        signed_mode = sm;
        early_exit_en = ee;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called in cycle t+1; returns in the done cycle with lat = cycles after t.
    task automatic wait_done();
        lat = 1;
        busy_cycles = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cycles++;
            tick();
            lat++;
        end
    endtask

    task automatic chk_result(input string tag, input logic l, input logic g, input logic e,
                              input logic [2:0] du, input int exp_lat);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_flags"}, {Lesser, Greater, Equal}, {l, g, e});
        chk({tag, "_du"}, digits_used, du);
        chk({tag, "_busycyc"}, busy_cycles, exp_lat - 1);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        signed_mode = 1'b0;
        early_exit_en = 1'b0;
        tick();
        tick();
        chk("reset_outs", {busy, done, Lesser, Greater, Equal, digits_used}, 8'h00);
        rst = 1'b0;
        tick();
        chk("idle_outs", {busy, done, Lesser, Greater, Equal, digits_used}, 8'h00);

        // 1: unsigned early exit on first digit
        issue(8'hA5, 8'h5A, 1'b0, 1'b1);
        chk("s1_busy_t1", busy, 1'b1);
        wait_done();
        chk_result("s1", 1'b0, 1'b1, 1'b0, 3'd1, 2);
        tick();
        chk("s1_done_width", done, 1'b0);
        chk("s1_hold", {Lesser, Greater, Equal, digits_used}, {1'b0, 1'b1, 1'b0, 3'd1});

        // 2: equal operands run all digits
        issue(8'h3C, 8'h3C, 1'b0, 1'b1);
        wait_done();
        chk_result("s2", 1'b0, 1'b0, 1'b1, 3'd4, 5);
        tick();

        // 3: signed vs unsigned interpretation of 0x80
        issue(8'h80, 8'h01, 1'b1, 1'b1);
        wait_done();
        chk_result("s3_signed", 1'b1, 1'b0, 1'b0, 3'd1, 2);
        tick();
        issue(8'h80, 8'h01, 1'b0, 1'b1);
        wait_done();
        chk_result("s3_unsigned", 1'b0, 1'b1, 1'b0, 3'd1, 2);
        tick();

        // 4: no early exit, later opposite digits must not flip result
        issue(8'hA5, 8'h5A, 1'b0, 1'b0);
        wait_done();
        chk_result("s4", 1'b0, 1'b1, 1'b0, 3'd4, 5);
        tick();

        // 5: start during RUN ignored; start in done cycle accepted
        issue(8'h10, 8'h20, 1'b0, 1'b0);
        tick();
        A = 8'hFF;
        B = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("s5_busy_t3", busy, 1'b1);
        tick();
        tick();
        chk("s5_done_t5", done, 1'b1);
        chk("s5_flags", {Lesser, Greater, Equal, digits_used}, {1'b1, 1'b0, 1'b0, 3'd4});
        issue(8'h01, 8'h01, 1'b0, 1'b1);
        chk("s5_b2b_clear", {busy, done, Lesser, Greater, Equal, digits_used}, 8'h80);
        wait_done();
        chk_result("s5_b2b", 1'b0, 1'b0, 1'b1, 3'd4, 5);
        tick();

        // 6: reset mid-run, then a fresh compare
        issue(8'h3C, 8'h3C, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s6_after_rst", {busy, done, Lesser, Greater, Equal, digits_used}, 8'h00);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("s6_no_done", {busy, done}, 2'b00);
        end
        issue(8'h01, 8'h02, 1'b0, 1'b1);
        wait_done();
        chk_result("s6_post", 1'b1, 1'b0, 1'b0, 3'd4, 5);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/comparator_serial_nbit.md
# comparator_serial_nbit

Multi-cycle, digit-serial magnitude comparator. It compares two N-bit operands W bits per cycle, most significant digit first, and supports both unsigned and two's-complement modes. Early exit on the first differing digit is optional. This is the sequential successor to the combinational N-bit comparator, intended for wide operands where a single-cycle compare would limit timing. It uses a start/busy/done handshake and holds its result registers until the next accepted start.

## Interface
- N, 8, operand width in bits; N must be a multiple of W.
- W, 2, digit width processed per cycle; 1 ≤ W ≤ N.
- DIGITS (localparam), N/W, number of digits.
- CW (localparam), $clog2(DIGITS+1), width of digits_used.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when the FSM is in IDLE.
- A  input  N  operand A; sampled only on the acceptance edge.
- B  input  N  operand B; sampled only on the acceptance edge.
- signed_mode  input  1  1 = two's-complement compare; sampled on acceptance.
- early_exit_en  input  1  1 = finish on the first differing digit; sampled on acceptance.
- busy  output  1  high while the comparison is in progress.
- done  output  1  one-cycle pulse when the result is valid.
- Lesser  output  1  A < B.
- Greater  output  1  A > B.
- Equal  output  1  A == B.
- digits_used  output  CW  number of digits examined in the last comparison.

## Operation
- FSM states: IDLE and RUN. The internal registers are the shift copies a_sh/b_sh (N bits each), a digit counter, a `decided` flag, and a pending-result register.
- **IDLE, start=1 (acceptance):**
  - Load a_sh=A and b_sh=B.
  - If signed_mode=1, invert bit N-1 of both. This offset-binary mapping makes an unsigned compare equivalent to the signed compare.
  - Clear the counter, `decided`, and Lesser/Greater/Equal/digits_used.
  - Go to RUN.
- **RUN, each cycle:** compare the top digits a_sh[N-1:N-W] and b_sh[N-1:N-W] as unsigned values.
  - If `decided`=0 and the digits differ, latch Greater or Lesser as pending and set `decided`=1.
  - Then shift both registers left by W and increment the counter.
- **Exit from RUN (to IDLE):** occurs on the first of the following:
  - (early_exit_en=1 and the current digits differ), or
  - the counter reaches DIGITS-1 (last digit).
- **On exit:**
  - Drive exactly one of Lesser/Greater/Equal to 1. Equal=1 only if no digit differed.
  - Set digits_used to the number of digits examined.
  - Pulse done.
- After `decided`=1, later digits never overwrite the result. This covers the early_exit_en=0 case.
- start during RUN is ignored, with no queuing. Operand changes during RUN have no effect.
- The result flags and digits_used hold their values until the next accepted start, which clears them.

## Timing
- **Reset values:** state=IDLE, busy=0, done=0, Lesser=0, Greater=0, Equal=0, digits_used=0. Before the first done, all-zero flags mean "no result".
- **rst dominance:** rst takes priority over start and over RUN. If asserted mid-comparison, the next cycle is IDLE with all outputs at reset values and no done pulse.
- **Latency:** start is accepted at the edge ending cycle t. Let k be the number of digits examined (1..DIGITS).
  - busy=1 in cycles t+1 .. t+k.
  - done=1 and the new flags are visible in cycle t+k+1, where busy=0.
  - With early exit disabled, k=DIGITS, so done arrives DIGITS+1 cycles after start.
- **done width:** done is high for exactly one cycle.
- **Back-to-back operation:**
  - A start asserted in the done cycle (FSM in IDLE) is accepted. The flags clear in the following cycle.
  - The minimum issue interval is k+1 cycles.
- **Degenerate W=N:** DIGITS=1 and every comparison takes k=1.
- **Flag exclusivity:** at most one of Lesser/Greater/Equal is ever high.

## Test plan
All scenarios use N=8, W=2.
1. Unsigned, early_exit_en=1, A=0xA5, B=0x5A → Greater=1, digits_used=1, done in cycle t+2, busy high for exactly 1 cycle.
2. Unsigned, early_exit_en=1, A=B=0x3C → Equal=1, digits_used=4, done in cycle t+5.
3. A=0x80, B=0x01, early_exit_en=1:
   - signed_mode=1 → Lesser=1, digits_used=1.
   - Repeat with signed_mode=0 → Greater=1, digits_used=1.
4. Unsigned, early_exit_en=0, A=0xA5, B=0x5A → Greater=1. The later opposite digits do not flip the result. digits_used=4, done in cycle t+5.
5. Start during RUN: start with A=0x10, B=0x20 (early_exit_en=0). Pulse start with A=0xFF, B=0x00 in cycle t+2 → that second start is ignored; result is Lesser=1 at t+5. A start in the done cycle is accepted and the flags read 0 in the next cycle.
6. Reset mid-run: assert rst in cycle t+2 of a 4-digit compare → next cycle busy=0, flags=0, digits_used=0, and no done pulse. A subsequent compare with A=0x01, B=0x02 → Lesser=1.
